// File: rtl/rv_id_opimm.sv
// rv_id_opimm: RV32I OP-IMM decode/issue stage with rs1 read, writeback bypass and a RAW/WAW scoreboard.
// Latency: one cycle; an instruction accepted at edge N drives ex_* with ex_valid=1 from edge N onward.
// Backpressure: if_ready drops while EX holds the register, on a scoreboard hazard, or during flush.
module rv_id_opimm #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  output logic [4:0]      rf_rs1_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_imm,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_r,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLLI    = 3'b001;
  localparam logic [2:0] F3_SRXI    = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Everything the EX stage needs for one instruction, carried as one register.
  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7_r;
    logic [4:0]      rd;
    logic            illegal;
  } ex_pkt_t;

  // Raw instruction fields.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rd_idx;

  assign opcode  = if_instr[6:0];
  assign funct3  = if_instr[14:12];
  assign funct7  = if_instr[31:25];
  assign rs1_idx = if_instr[19:15];
  assign rd_idx  = if_instr[11:7];

  assign rf_rs1_addr = rs1_idx;

  // State.
  ex_pkt_t     ex_q;
  logic [31:0] sb;

  // Decode and handshake intermediates.
  ex_pkt_t         dec;
  logic            legal;
  logic [XLEN-1:0] rs1_val;
  logic [31:0]     wb_clr;
  logic [31:0]     ex_claim;
  logic [31:0]     pend;
  logic [31:0]     sb_set;
  logic [31:0]     sb_nxt;
  logic            hazard;
  logic            accept;
  logic            handoff;

  // rs1 operand: x0 is hardwired zero, a same-cycle writeback beats the stale RF read.
  always_comb begin
    rs1_val = rf_rs1_data;
    if (rs1_idx == 5'd0) begin
      rs1_val = '0;
    end else if (wb_en && (wb_rd == rs1_idx)) begin
      rs1_val = wb_data;
    end
  end

  // OP-IMM decode; illegal encodings keep funct3/rs1 but zero out rd, imm and the funct7 qualifier.
  always_comb begin
    dec        = '0;
    dec.rs1    = rs1_val;
    dec.funct3 = funct3;
    legal      = 1'b0;
    if (opcode == OPC_OP_IMM) begin
      case (funct3)
        F3_SLLI: legal = (funct7 == F7_BASE);
        F3_SRXI: legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        default: legal = 1'b1;
      endcase
    end
    dec.illegal = !legal;
    if (legal) begin
      dec.rd = rd_idx;
      if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
        dec.imm      = {{(XLEN-5){1'b0}}, if_instr[24:20]};
        dec.funct7_r = (funct3 == F3_SRXI) && if_instr[30];
      end else begin
        dec.imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
    end
  end

  // Pending registers: scoreboard bits not retiring this cycle, plus the rd still sitting in our register.
  always_comb begin
    wb_clr   = wb_en ? (32'd1 << wb_rd) : 32'd0;
    ex_claim = (ex_valid && !ex_q.illegal) ? (32'd1 << ex_q.rd) : 32'd0;
    pend     = (sb & ~wb_clr) | ex_claim;
  end

  // Hazard only for legal instructions; x0 never creates a dependency.
  always_comb begin
    hazard = 1'b0;
    if (legal) begin
      hazard = ((rs1_idx != 5'd0) && pend[rs1_idx]) ||
               ((rd_idx  != 5'd0) && pend[rd_idx]);
    end
  end

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign handoff  = ex_valid && ex_ready;

  // Scoreboard update: a handoff marks its rd in flight, a writeback retires it, set beats clear.
  always_comb begin
    sb_set    = (handoff && !ex_q.illegal) ? (32'd1 << ex_q.rd) : 32'd0;
    sb_nxt    = (sb & ~wb_clr) | sb_set;
    sb_nxt[0] = 1'b0;
  end

  // Pipeline register: reload on accept, drop on handoff or flush, otherwise hold for a stalled EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_q     <= dec;
    end else if (handoff || flush) begin
      ex_valid <= 1'b0;
    end
  end

  // Scoreboard register; flush leaves it alone because older instructions still write back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb <= sb_nxt;
    end
  end

  assign ex_rs1      = ex_q.rs1;
  assign ex_imm      = ex_q.imm;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7_r = ex_q.funct7_r;
  assign ex_rd       = ex_q.rd;
  assign ex_illegal  = ex_q.illegal;

endmodule
